// File: rtl/multicycle_control_unit_if.sv
// Handshake and control bundle between the multicycle sequencer
// and its instruction source, memory and datapath.
interface multicycle_control_unit_if #(
    parameter int OP_W      = 4,
    parameter int REG_SEL_W = 3,
    parameter int DATA_W    = 8,
    parameter int PC_W      = 8
);
    localparam int INSTR_W  = OP_W + 2 * REG_SEL_W;
    localparam int NUM_REGS = 2 ** REG_SEL_W;

    logic                 instr_valid;
    logic [INSTR_W-1:0]   instruction;
    logic                 instr_ready;
    logic                 mem_ready;
    logic [REG_SEL_W-1:0] reg_a_select;
    logic [REG_SEL_W-1:0] reg_b_select;
    logic [NUM_REGS-1:0]  write_enable;
    logic [3:0]           g_select;
    logic [1:0]           mb_select;
    logic                 mf_select;
    logic                 md_select;
    logic                 mem_read;
    logic                 mem_write;
    logic                 load;
    logic [PC_W-1:0]      set_value;
    logic [DATA_W-1:0]    constant_in;
    logic                 pc_inc;
    logic                 illegal;
    logic                 busy;

    modport master (
        input  instr_valid, instruction, mem_ready,
        output instr_ready, reg_a_select, reg_b_select,
        output write_enable, g_select, mb_select,
        output mf_select, md_select, mem_read, mem_write,
        output load, set_value, constant_in, pc_inc,
        output illegal, busy
    );

    modport slave (
        output instr_valid, instruction, mem_ready,
        input  instr_ready, reg_a_select, reg_b_select,
        input  write_enable, g_select, mb_select,
        input  mf_select, md_select, mem_read, mem_write,
        input  load, set_value, constant_in, pc_inc,
        input  illegal, busy
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Five-state FETCH/DECODE/EXEC/MEM/WB sequencer producing registered
// register-file, ALU, memory and PC controls for a small datapath.
module multicycle_control_unit #(
    parameter int OP_W        = 4,
    parameter int REG_SEL_W   = 3,
    parameter int DATA_W      = 8,
    parameter int PC_W        = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input logic clk,
    input logic rst,
    multicycle_control_unit_if.master bus
);
    localparam int INSTR_W  = OP_W + 2 * REG_SEL_W;
    localparam int NUM_REGS = 2 ** REG_SEL_W;
    localparam int CNT_W    = $clog2(MEM_TIMEOUT + 1);

    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUBI  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_MUL2  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_DIV2  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_CLR   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_RST   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_MOV   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_JMP   = OP_W'(9);
    localparam logic [OP_W-1:0] OP_OUT   = OP_W'(10);
    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(12);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] mb;
        logic       mf;
        logic       wr_one;
        logic       wr_all;
        logic       mem;
        logic       ld;
        logic       jmp;
        logic       bad;
    } dec_t;

    function automatic dec_t decode(input logic [OP_W-1:0] op);
        dec_t r;
        r = '0;
        case (op)
            OP_ADD:   begin r.g = 4'b0001; r.wr_one = 1'b1; end
            OP_SUB:   begin r.g = 4'b0010; r.wr_one = 1'b1; end
            OP_ADDI:  begin r.g = 4'b0001; r.mb = 2'b01; r.wr_one = 1'b1; end
            OP_SUBI:  begin r.g = 4'b0010; r.mb = 2'b01; r.wr_one = 1'b1; end
            OP_MUL2:  begin r.g = 4'b0100; r.mf = 1'b1; r.wr_one = 1'b1; end
            OP_DIV2:  begin r.g = 4'b0101; r.mf = 1'b1; r.wr_one = 1'b1; end
            OP_CLR:   begin r.mb = 2'b10; r.wr_one = 1'b1; end
            OP_RST:   begin r.mb = 2'b10; r.wr_all = 1'b1; end
            OP_MOV:   begin r.g = 4'b0011; r.wr_one = 1'b1; end
            OP_JMP:   r.jmp = 1'b1;
            OP_OUT:   r.bad = 1'b0;
            OP_LOAD:  begin r.mem = 1'b1; r.ld = 1'b1; r.wr_one = 1'b1; end
            OP_STORE: r.mem = 1'b1;
            default:  r.bad = 1'b1;
        endcase
        return r;
    endfunction

    state_t                 state;
    logic [INSTR_W-1:0]     ir;
    logic [CNT_W-1:0]       cnt;
    dec_t                   d;
    logic [NUM_REGS-1:0]    wb_we;
    logic [OP_W-1:0]        ir_op;
    logic [REG_SEL_W-1:0]   ir_ra;
    logic [2*REG_SEL_W-1:0] ir_lo;
    logic [REG_SEL_W-1:0]   in_ra;
    logic [REG_SEL_W-1:0]   in_rb;

    assign ir_op = ir[INSTR_W-1 -: OP_W];
    assign ir_ra = ir[2*REG_SEL_W-1 -: REG_SEL_W];
    assign ir_lo = ir[2*REG_SEL_W-1:0];
    assign in_ra = bus.instruction[2*REG_SEL_W-1 -: REG_SEL_W];
    assign in_rb = bus.instruction[REG_SEL_W-1:0];

    // Decode the held instruction and form its writeback strobe pattern.
    always_comb begin
        d     = decode(ir_op);
        wb_we = '0;
        if (d.wr_all)
            wb_we = '1;
        else if (d.wr_one)
            wb_we = NUM_REGS'(1) << ir_ra;
    end

    // Sequencer state, instruction register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= FETCH;
            ir               <= '0;
            cnt              <= '0;
            bus.instr_ready  <= 1'b0;
            bus.busy         <= 1'b0;
            bus.reg_a_select <= '0;
            bus.reg_b_select <= '0;
            bus.constant_in  <= '0;
            bus.write_enable <= '0;
            bus.g_select     <= '0;
            bus.mb_select    <= '0;
            bus.mf_select    <= 1'b0;
            bus.md_select    <= 1'b0;
            bus.mem_read     <= 1'b0;
            bus.mem_write    <= 1'b0;
            bus.load         <= 1'b0;
            bus.set_value    <= '0;
            bus.pc_inc       <= 1'b0;
            bus.illegal      <= 1'b0;
        end else begin
            bus.write_enable <= '0;
            bus.g_select     <= '0;
            bus.mb_select    <= '0;
            bus.mf_select    <= 1'b0;
            bus.md_select    <= 1'b0;
            bus.mem_read     <= 1'b0;
            bus.mem_write    <= 1'b0;
            bus.load         <= 1'b0;
            bus.set_value    <= '0;
            bus.pc_inc       <= 1'b0;
            bus.illegal      <= 1'b0;
            case (state)
                FETCH: begin
                    if (bus.instr_valid && bus.instr_ready) begin
                        ir               <= bus.instruction;
                        state            <= DECODE;
                        bus.instr_ready  <= 1'b0;
                        bus.busy         <= 1'b1;
                        bus.reg_a_select <= in_ra;
                        bus.reg_b_select <= in_rb;
                        bus.constant_in  <= DATA_W'(in_rb);
                    end else begin
                        bus.instr_ready  <= 1'b1;
                    end
                end
                DECODE: begin
                    state         <= EXEC;
                    bus.g_select  <= d.g;
                    bus.mb_select <= d.mb;
                    bus.mf_select <= d.mf;
                    bus.illegal   <= d.bad;
                    bus.load      <= d.jmp;
                    if (d.jmp)
                        bus.set_value <= PC_W'(ir_lo);
                end
                EXEC: begin
                    if (d.mem) begin
                        state         <= MEM;
                        cnt           <= '0;
                        bus.mem_read  <= d.ld;
                        bus.mem_write <= !d.ld;
                    end else if (d.jmp) begin
                        state           <= FETCH;
                        bus.instr_ready <= 1'b1;
                        bus.busy        <= 1'b0;
                    end else begin
                        state            <= WB;
                        bus.write_enable <= wb_we;
                        bus.g_select     <= d.g;
                        bus.mb_select    <= d.mb;
                        bus.mf_select    <= d.mf;
                        bus.pc_inc       <= 1'b1;
                    end
                end
                MEM: begin
                    if (bus.mem_ready) begin
                        state            <= WB;
                        bus.write_enable <= wb_we;
                        bus.md_select    <= d.ld;
                        bus.pc_inc       <= 1'b1;
                    end else if (cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                        state           <= FETCH;
                        cnt             <= '0;
                        bus.illegal     <= 1'b1;
                        bus.instr_ready <= 1'b1;
                        bus.busy        <= 1'b0;
                    end else begin
                        cnt           <= cnt + 1'b1;
                        bus.mem_read  <= d.ld;
                        bus.mem_write <= !d.ld;
                    end
                end
                default: begin
                    state           <= FETCH;
                    bus.instr_ready <= 1'b1;
                    bus.busy        <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomised bench for multicycle_control_unit: per-cycle scoreboard
// against a table-driven model, plus directed literal and reset checks.
module tb_multicycle_control_unit;
    localparam int MT = 15;

    localparam logic [3:0] G_TAB [16] = '{
        4'd1, 4'd2, 4'd1, 4'd2, 4'd4, 4'd5, 4'd0, 4'd0,
        4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    localparam logic [1:0] MB_TAB [16] = '{
        2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2,
        2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    // opcodes that write the single register ra
    localparam logic [15:0] WR_MASK = 16'h097F;

    logic clk;
    logic rst;

    multicycle_control_unit_if #(
        .OP_W(4), .REG_SEL_W(3), .DATA_W(8), .PC_W(8)
    ) bus0 ();
    multicycle_control_unit_if #(
        .OP_W(4), .REG_SEL_W(4), .DATA_W(8), .PC_W(8)
    ) bus1 ();

    multicycle_control_unit #(
        .OP_W(4), .REG_SEL_W(3), .DATA_W(8), .PC_W(8),
        .MEM_TIMEOUT(MT)
    ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    multicycle_control_unit #(
        .OP_W(4), .REG_SEL_W(4), .DATA_W(8), .PC_W(8),
        .MEM_TIMEOUT(MT)
    ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic       rdy, busy, rd, wr, load, pci, ill, mf, md;
        logic [7:0] we, sv, cst;
        logic [3:0] g;
        logic [1:0] mb;
        logic [2:0] ra, rb;
        bit         c_alu, c_wb, c_sel, c_sv;
    } obs_t;

    int   errors = 0;
    int   checks = 0;
    obs_t q[$];
    obs_t snap[64];
    int   sidx = 0;
    bit   pend = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    function automatic obs_t idle_obs();
        obs_t o;
        o = '{default: '0};
        o.rdy = 1'b1;
        return o;
    endfunction

    function automatic obs_t busy_obs(input logic [2:0] ra,
                                      input logic [2:0] rb);
        obs_t o;
        o = '{default: '0};
        o.busy  = 1'b1;
        o.c_sel = 1'b1;
        o.ra    = ra;
        o.rb    = rb;
        o.cst   = {5'b0, rb};
        return o;
    endfunction

    // Expected EXEC (wb=0) or WB (wb=1) cycle of an instruction.
    function automatic obs_t phase(input logic [3:0] op,
                                   input logic [2:0] ra,
                                   input logic [2:0] rb, input bit wb);
        obs_t o;
        o = busy_obs(ra, rb);
        o.c_alu = 1'b1;
        o.g  = G_TAB[op];
        o.mb = MB_TAB[op];
        o.mf = (op == 4'd4 || op == 4'd5);
        if (wb) begin
            o.c_wb = 1'b1;
            o.pci  = 1'b1;
            o.md   = (op == 4'd11);
            if (op == 4'd7)
                o.we = 8'hFF;
            else if (WR_MASK[op])
                o.we = 8'h01 << ra;
        end else begin
            o.ill  = (op >= 4'd13);
            o.load = (op == 4'd9);
            o.c_sv = (op == 4'd9);
            o.sv   = {2'b00, ra, rb};
        end
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t a;
        a = '{default: '0};
        a.rdy  = bus0.instr_ready;
        a.busy = bus0.busy;
        a.rd   = bus0.mem_read;
        a.wr   = bus0.mem_write;
        a.load = bus0.load;
        a.pci  = bus0.pc_inc;
        a.ill  = bus0.illegal;
        a.mf   = bus0.mf_select;
        a.md   = bus0.md_select;
        a.we   = bus0.write_enable;
        a.sv   = bus0.set_value;
        a.cst  = bus0.constant_in;
        a.g    = bus0.g_select;
        a.mb   = bus0.mb_select;
        a.ra   = bus0.reg_a_select;
        a.rb   = bus0.reg_b_select;
        return a;
    endfunction

    // Scoreboard: one expected record per clock cycle.
    always @(negedge clk) begin
        obs_t e, a;
        if (!rst && q.size() != 0) begin
            e = q.pop_front();
            a = sample();
            chk("instr_ready", 32'(a.rdy), 32'(e.rdy));
            chk("busy", 32'(a.busy), 32'(e.busy));
            chk("write_enable", 32'(a.we), 32'(e.we));
            chk("mem_read", 32'(a.rd), 32'(e.rd));
            chk("mem_write", 32'(a.wr), 32'(e.wr));
            chk("load", 32'(a.load), 32'(e.load));
            chk("pc_inc", 32'(a.pci), 32'(e.pci));
            chk("illegal", 32'(a.ill), 32'(e.ill));
            if (e.c_alu) begin
                chk("g_select", 32'(a.g), 32'(e.g));
                chk("mb_select", 32'(a.mb), 32'(e.mb));
                chk("mf_select", 32'(a.mf), 32'(e.mf));
            end
            if (e.c_wb)
                chk("md_select", 32'(a.md), 32'(e.md));
            if (e.c_sv)
                chk("set_value", 32'(a.sv), 32'(e.sv));
            if (e.c_sel) begin
                chk("reg_a_select", 32'(a.ra), 32'(e.ra));
                chk("reg_b_select", 32'(a.rb), 32'(e.rb));
                chk("constant_in", 32'(a.cst), 32'(e.cst));
            end
        end
    end

    task automatic step(input obs_t e);
        q.push_back(e);
        if (sidx < 64)
            snap[sidx] = sample();
        sidx++;
        @(posedge clk);
        #1;
    endtask

    task automatic junk();
        bus0.instr_valid = 1'($urandom);
        bus0.instruction = 10'($urandom);
        bus0.mem_ready   = 1'($urandom);
    endtask

    task automatic idle_cycle();
        obs_t e;
        bus0.instr_valid = 1'b0;
        bus0.instruction = 10'($urandom);
        bus0.mem_ready   = 1'($urandom);
        e = idle_obs();
        e.ill = pend;
        pend = 0;
        step(e);
    endtask

    // Offer one instruction; k is the MEM cycle on which mem_ready rises.
    task automatic run(input logic [3:0] op, input logic [2:0] ra,
                       input logic [2:0] rb, input int k);
        obs_t e;
        sidx = 0;
        bus0.instr_valid = 1'b1;
        bus0.instruction = {op, ra, rb};
        bus0.mem_ready   = 1'($urandom);
        e = idle_obs();
        e.ill = pend;
        pend = 0;
        step(e);
        junk();
        step(busy_obs(ra, rb));
        junk();
        step(phase(op, ra, rb, 1'b0));
        if (op == 4'd9)
            return;
        if (op == 4'd11 || op == 4'd12) begin
            for (int j = 1; j <= MT && j <= k; j++) begin
                junk();
                bus0.mem_ready = (j == k);
                e = busy_obs(ra, rb);
                e.rd = (op == 4'd11);
                e.wr = (op == 4'd12);
                step(e);
            end
            if (k > MT) begin
                pend = 1;
                return;
            end
        end
        junk();
        step(phase(op, ra, rb, 1'b1));
    endtask

    function automatic int count_rd();
        int n = 0;
        for (int i = 0; i < sidx && i < 64; i++) n += int'(snap[i].rd);
        return n;
    endfunction

    function automatic int count_ill();
        int n = 0;
        for (int i = 0; i < sidx && i < 64; i++) n += int'(snap[i].ill);
        return n;
    endfunction

    function automatic int count_pci();
        int n = 0;
        for (int i = 0; i < sidx && i < 64; i++) n += int'(snap[i].pci);
        return n;
    endfunction

    function automatic int count_we();
        int n = 0;
        for (int i = 0; i < sidx && i < 64; i++)
            n += int'(snap[i].we != 8'h00);
        return n;
    endfunction

    task automatic wide(input logic [3:0] ra);
        chk("wide_ready", 32'(bus1.instr_ready), 32'd1);
        bus1.instr_valid = 1'b1;
        bus1.instruction = {4'd0, ra, 4'd3};
        @(posedge clk); #1;
        bus1.instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("wide_we", 32'(bus1.write_enable), 32'(16'h0001 << ra));
        chk("wide_pc_inc", 32'(bus1.pc_inc), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        obs_t e;
        logic [3:0] op;
        logic [2:0] ra, rb;
        rst = 1'b1;
        bus0.instr_valid = 1'b0;
        bus0.instruction = '0;
        bus0.mem_ready   = 1'b0;
        bus1.instr_valid = 1'b0;
        bus1.instruction = '0;
        bus1.mem_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus0.instr_ready), 32'd0);
        chk("rst_busy", 32'(bus0.busy), 32'd0);
        chk("rst_we", 32'(bus0.write_enable), 32'd0);
        chk("rst_cst", 32'(bus0.constant_in), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(bus0.instr_ready), 32'd1);

        run(4'd0, 3'd1, 3'd5, 0);
        idle_cycle();
        chk("add_g", 32'(snap[2].g), 32'd1);
        chk("add_mb", 32'(snap[2].mb), 32'd0);
        chk("add_we", 32'(snap[3].we), 32'h02);
        chk("add_pc_inc", 32'(snap[3].pci), 32'd1);
        chk("add_ready_wb", 32'(snap[3].rdy), 32'd0);
        chk("add_ready_4", 32'(snap[4].rdy), 32'd1);

        run(4'd2, 3'd5, 3'd3, 0);
        chk("addi_cst", 32'(snap[2].cst), 32'h03);
        chk("addi_mb", 32'(snap[2].mb), 32'd1);
        chk("addi_we", 32'(snap[3].we), 32'h20);

        run(4'd9, 3'd0, 3'd7, 0);
        idle_cycle();
        chk("jmp_load", 32'(snap[2].load), 32'd1);
        chk("jmp_sv", 32'(snap[2].sv), 32'h07);
        chk("jmp_pc_inc", 32'(count_pci()), 32'd0);
        chk("jmp_ready_3", 32'(snap[3].rdy), 32'd1);

        run(4'd11, 3'd5, 3'd2, 3);
        idle_cycle();
        chk("load_rd_cycles", 32'(count_rd()), 32'd3);
        chk("load_we", 32'(snap[6].we), 32'h20);
        chk("load_md", 32'(snap[6].md), 32'd1);
        chk("load_ready", 32'(snap[7].rdy), 32'd1);

        run(4'd11, 3'd5, 3'd2, 100);
        idle_cycle();
        chk("tmo_rd_cycles", 32'(count_rd()), 32'd15);
        chk("tmo_illegal", 32'(snap[18].ill), 32'd1);
        chk("tmo_ill_count", 32'(count_ill()), 32'd1);
        chk("tmo_no_write", 32'(count_we()), 32'd0);
        chk("tmo_no_pc_inc", 32'(count_pci()), 32'd0);

        run(4'd7, 3'd2, 3'd2, 0);
        chk("rst_op_we", 32'(snap[3].we), 32'hFF);

        run(4'd15, 3'd3, 3'd1, 0);
        idle_cycle();
        chk("bad_illegal", 32'(snap[2].ill), 32'd1);
        chk("bad_ill_count", 32'(count_ill()), 32'd1);
        chk("bad_no_write", 32'(count_we()), 32'd0);
        chk("bad_pc_inc", 32'(snap[3].pci), 32'd1);

        repeat (150) begin
            op = 4'($urandom_range(0, 15));
            ra = 3'($urandom);
            rb = 3'($urandom);
            run(op, ra, rb, int'($urandom_range(1, 18)));
            repeat ($urandom_range(0, 2)) idle_cycle();
        end
        idle_cycle();

        sidx = 0;
        bus0.instr_valid = 1'b1;
        bus0.instruction = {4'd12, 3'd4, 3'd1};
        bus0.mem_ready   = 1'b0;
        e = idle_obs();
        step(e);
        bus0.instr_valid = 1'b0;
        step(busy_obs(3'd4, 3'd1));
        step(phase(4'd12, 3'd4, 3'd1, 1'b0));
        e = busy_obs(3'd4, 3'd1);
        e.wr = 1'b1;
        step(e);
        chk("st_wr_before", 32'(bus0.mem_write), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("st_wr_rst", 32'(bus0.mem_write), 32'd0);
        chk("st_busy_rst", 32'(bus0.busy), 32'd0);
        chk("st_ready_rst", 32'(bus0.instr_ready), 32'd0);
        @(posedge clk); #1;
        chk("st_hold_we", 32'(bus0.write_enable), 32'd0);
        chk("st_hold_pci", 32'(bus0.pc_inc), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("st_ready_after", 32'(bus0.instr_ready), 32'd1);
        chk("st_no_wr_after", 32'(bus0.mem_write), 32'd0);
        chk("st_no_we_after", 32'(bus0.write_enable), 32'd0);
        chk("st_no_pci_after", 32'(bus0.pc_inc), 32'd0);
        run(4'd1, 3'd3, 3'd4, 0);
        idle_cycle();

        for (int r = 0; r < 16; r++)
            wide(4'(r));

        repeat (2) @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter OP_W, default 4, opcode width.
REQ-002 SHALL have parameter REG_SEL_W, default 3, register-select width; NUM_REGS = 2**REG_SEL_W.
REQ-003 SHALL have parameter DATA_W, default 8, constant_in width.
REQ-004 SHALL have parameter PC_W, default 8, set_value width.
REQ-005 SHALL have parameter MEM_TIMEOUT, default 15, maximum MEM-state wait cycles.
REQ-006 SHALL have derived INSTR_W = OP_W + 2*REG_SEL_W:
- opcode = instruction[INSTR_W-1 -: OP_W]
- ra = next REG_SEL_W bits
- rb = low REG_SEL_W bits
REQ-007 SHALL use one clock and an asynchronous, active-high reset, with ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- instr_valid  in  1  instruction offered
- instruction  in  INSTR_W  instruction word
- instr_ready  out  1  FSM accepts instruction
- mem_ready  in  1  memory completes access
- reg_a_select, reg_b_select  out  REG_SEL_W  register-file read ports
- write_enable  out  NUM_REGS  register write strobes
- g_select  out  4  ALU function
- mb_select  out  2  B-operand mux (00 reg, 01 constant, 10 zero)
- mf_select  out  1  1 = shifter result
- md_select  out  1  1 = memory data to writeback
- mem_read, mem_write  out  1  memory strobes
- load  out  1  PC load
- set_value  out  PC_W  PC target
- constant_in  out  DATA_W  immediate
- pc_inc  out  1  PC increment pulse
- illegal  out  1  illegal-opcode/timeout pulse
- busy  out  1  FSM not in FETCH

Function
REQ-008 SHALL implement states FETCH, DECODE, EXEC, MEM, WB.
REQ-009 FETCH: instr_ready = 1; on instr_valid && instr_ready, SHALL latch instruction into internal IR and go to DECODE; otherwise stay.
REQ-010 DECODE SHALL last exactly one cycle and then go to EXEC; reg_a_select = ra and reg_b_select = rb from IR in DECODE, EXEC, MEM and WB.
REQ-011 EXEC SHALL drive these datapath controls for one cycle (all other controls 0):
- 0000 ADD: g=0001, mb=00
- 0001 SUB: g=0010, mb=00
- 0010 ADDI: g=0001, mb=01
- 0011 SUBI: g=0010, mb=01
- 0100 MUL2: g=0100, mf=1
- 0101 DIV2: g=0101, mf=1
- 0110 CLR: g=0000, mb=10
- 0111 RST: g=0000, mb=10
- 1000 MOV: g=0011, mb=00
- 1010 OUT: no write
- 1011 LOAD / 1100 STORE: go to MEM
REQ-012 constant_in SHALL equal rb zero-extended to DATA_W whenever IR is valid; 0 otherwise.
REQ-013 JMP (1001) SHALL assert load = 1 in EXEC with set_value = low 2*REG_SEL_W IR bits, zero-extended or truncated to PC_W; JMP SHALL skip WB and SHALL NOT assert pc_inc.
REQ-014 MEM SHALL hold mem_read (LOAD) or mem_write (STORE) high until the cycle mem_ready = 1, then go to WB.
- If MEM_TIMEOUT cycles elapse without mem_ready: SHALL pulse illegal for 1 cycle, drop strobes, and go to FETCH without write or pc_inc.
REQ-015 WB SHALL last one cycle, pulse pc_inc = 1, and assert write_enable:
- one-hot at ra for ADD, SUB, ADDI, SUBI, MUL2, DIV2, CLR, MOV, LOAD
- all ones for RST
- zero for OUT and STORE
- LOAD additionally sets md_select = 1
WB SHALL repeat the EXEC g, mb and mf values so the writeback data is stable.
REQ-016 Opcodes 1101-1111 SHALL pulse illegal in EXEC, with no write or memory strobe, then go to WB with write_enable = 0 and pc_inc = 1.
REQ-017 write_enable SHALL never be nonzero outside WB.
REQ-018 Latency from acceptance: ALU/OUT 4 cycles to FETCH; JMP 3 cycles; LOAD/STORE 4 + memory-wait cycles.
REQ-019 busy SHALL equal (state != FETCH).

Reset
REQ-020 rst high SHALL asynchronously force FETCH, clear IR and the timeout counter, and force every output to 0, including instr_ready.
REQ-021 instr_ready SHALL assert in the first cycle after rst deasserts; reset mid-MEM or mid-WB SHALL abort with no write_enable, strobe, load or pc_inc pulse.

Verification
REQ-022 ADD ra=001 rb=101 accepted -> EXEC g=0001, mb=00; WB write_enable=00000010, pc_inc=1; instr_ready again 4 cycles after accept.
REQ-023 ADDI instruction=0010101011 -> constant_in=00000011, mb=01; WB write_enable=00100000.
REQ-024 JMP instruction=1001000111 -> load=1 for one cycle, set_value=00000111, pc_inc never high, back in FETCH after 3 cycles.
REQ-025 LOAD ra=101, mem_ready after 3 cycles -> mem_read high exactly 3 cycles; WB write_enable=00100000, md_select=1. Repeat with mem_ready never asserted -> illegal pulse after 15 cycles, no write.
REQ-026 RST opcode -> WB write_enable=11111111. Opcode 1111 -> illegal=1 one cycle, write_enable stays 0.
REQ-027 rst asserted during STORE MEM -> mem_write drops in the same cycle; no WB; instr_ready=1 in the first cycle after release. Rerun with REG_SEL_W=4 -> write_enable width 16, one-hot correct.
